tetris_move_sched: RTL and testbench
====================================

Name: tetris_move_sched

Overview:
- Scheduler that sequences every motion command the falling-piece datapath executes. Gravity ticks, soft drop, rotate and left/right requests become a single command stream toward the board datapath.
- Arbitrates simultaneous sources with fixed priority and issues one command at a time over a valid/ready handshake.
- Sits between the input conditioning (buttons) and the tetromino position/collision logic. It replaces the datapath's free-running drop clock with a level-dependent gravity timer.

Parameters:
- CW, 24, width of all timing counters.
- GRAV_BASE, 1000000, gravity period at level 0, in clk cycles.
- GRAV_STEP, 60000, period reduction per level.
- GRAV_MIN, 100000, floor on gravity period; also the soft-drop period.
- DAS_DELAY, 300000, cycles a left/right must be held before auto-repeat starts.
- DAS_REPEAT, 100000, auto-repeat interval after DAS_DELAY.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- enable_i  in  1  high while the game is in the falling phase; low freezes the scheduler.
- level_i  in  4  current level, 0..15.
- left_i  in  1  synchronized, level-sensitive left button.
- right_i  in  1  synchronized, level-sensitive right button.
- rotate_i  in  1  synchronized rotate button.
- drop_i  in  1  soft-drop held.
- lock_i  in  1  one-cycle pulse: piece has landed/locked.
- cmd_valid_o  out  1  command available.
- cmd_o  out  3  command: 0 NONE, 1 LEFT, 2 RIGHT, 3 ROTATE, 4 DOWN.
- cmd_ready_i  in  1  datapath accepts the command this cycle.
- grav_period_o  out  CW  gravity period currently in effect (debug/score use).

Behaviour:
- Reset values: cmd_valid_o=0, cmd_o=0, grav_period_o=GRAV_BASE, all counters 0, all pending flags 0, FSM=IDLE.
- Period arithmetic: p = GRAV_BASE − level_i*GRAV_STEP, computed at CW+4 bits.
  - If the result underflows or p < GRAV_MIN, use GRAV_MIN.
  - drop_i=1 forces GRAV_MIN.
  - Registered into grav_period_o each cycle.
- Gravity: grav_cnt increments while enable_i. When grav_cnt == grav_period_o−1, set grav_pend and wrap grav_cnt to 0. A period change mid-count does not reset the count; if grav_cnt ≥ new period, the next cycle fires and wraps.
- Rotate: a rising edge of rotate_i sets rot_pend. Holding rotate_i does not repeat.
- Left/right (DAS): a rising edge sets mv_pend with the direction latched and das_cnt cleared.
  - While held, das_cnt counts; at DAS_DELAY−1, set mv_pend again and enter repeat mode.
  - In repeat mode, set mv_pend every DAS_REPEAT cycles.
  - Release clears das_cnt and repeat mode.
  - left_i&right_i both high: no move pends; DAS state cleared.
- Pending flags are single bits. Duplicate events before issue merge, with no queueing.
- FSM:
  - IDLE: if any pend, select the highest priority (ROTATE > LEFT/RIGHT > DOWN), register cmd_o and assert cmd_valid_o next cycle, then go to ISSUE.
  - ISSUE: hold cmd_valid_o and cmd_o stable until cmd_ready_i.
  - On transfer: clear the matching pend flag, deassert cmd_valid_o, return to IDLE.
  - Minimum spacing is one IDLE cycle between commands.
- Latency: event at cycle N → cmd_valid_o high at N+1 when IDLE; ready sampled at N+1 → next command no earlier than N+3.
- Events arriving during ISSUE set their flags normally. The command in flight is never changed.
- lock_i (highest priority, any state): clear all pends, grav_cnt, das_cnt and repeat mode. Force cmd_valid_o=0 and cmd_o=0 the next cycle and go to IDLE. An in-flight command is aborted; the datapath must ignore cmd_o without valid. A button still held after lock_i needs a fresh edge.
- enable_i=0: counters held at 0, no new pends, existing pends cleared, cmd_valid_o dropped next cycle, FSM to IDLE. Edge detectors keep tracking so the first enabled cycle sees no false edge.
- Asynchronous reset mid-handshake returns all outputs to reset values immediately.

Test Plan:
- Params GRAV_BASE=20, GRAV_STEP=2, GRAV_MIN=4, DAS_DELAY=6, DAS_REPEAT=3; level_i=0, enable_i=1, cmd_ready_i=1 → DOWN valid every 20 cycles; level_i=9 → period 4 (floored at GRAV_MIN, not 2).
- Pulse rotate_i for 1 cycle and a gravity tick in the same cycle → ROTATE issued first, DOWN next; cmd_o=3 then 4.
- Hold left_i 15 cycles with ready=1 → LEFT at edge+1, then at edge+7, +10, +13; release → no further LEFT.
- cmd_ready_i=0 for 8 cycles with cmd ROTATE pending → cmd_valid_o=1 and cmd_o=3 stable all 8 cycles; a second rotate edge during the stall yields exactly one extra ROTATE.
- lock_i during ISSUE(RIGHT) with right_i held → valid low next cycle, no RIGHT reissued until right_i is released and re-pressed; grav_cnt restarts from 0.
- left_i and right_i both held 10 cycles → no LEFT/RIGHT issued; DOWN still issued on gravity.

Source files
------------

// File: rtl/tetris_move_sched.sv
// Motion-command scheduler for the falling piece: gravity timer, rotate edges and
// DAS left/right auto-repeat merged into one prioritised valid/ready command stream.
module tetris_move_sched #(
  parameter int CW         = 24,
  parameter int GRAV_BASE  = 1000000,
  parameter int GRAV_STEP  = 60000,
  parameter int GRAV_MIN   = 100000,
  parameter int DAS_DELAY  = 300000,
  parameter int DAS_REPEAT = 100000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable_i,
  input  logic [3:0]    level_i,
  input  logic          left_i,
  input  logic          right_i,
  input  logic          rotate_i,
  input  logic          drop_i,
  input  logic          lock_i,
  output logic          cmd_valid_o,
  output logic [2:0]    cmd_o,
  input  logic          cmd_ready_i,
  output logic [CW-1:0] grav_period_o
);

  typedef enum logic {IDLE, ISSUE} state_t;

  localparam logic [2:0] CMD_NONE   = 3'd0;
  localparam logic [2:0] CMD_LEFT   = 3'd1;
  localparam logic [2:0] CMD_RIGHT  = 3'd2;
  localparam logic [2:0] CMD_ROTATE = 3'd3;
  localparam logic [2:0] CMD_DOWN   = 3'd4;

  localparam int PW = CW + 4;
  localparam logic [PW-1:0] BASE_W   = PW'(GRAV_BASE);
  localparam logic [PW-1:0] STEP_W   = PW'(GRAV_STEP);
  localparam logic [PW-1:0] MIN_W    = PW'(GRAV_MIN);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] DLY_LAST = CW'(DAS_DELAY - 1);
  localparam logic [CW-1:0] REP_LAST = CW'(DAS_REPEAT - 1);

  state_t        state_reg, state_next;
  logic          cmd_valid_reg, cmd_valid_next;
  logic [2:0]    cmd_reg, cmd_next;
  logic [CW-1:0] grav_period_reg, period_next;
  logic [CW-1:0] grav_cnt_reg, grav_cnt_next;
  logic [CW-1:0] das_cnt_reg, das_cnt_next;
  logic          das_active_reg, das_active_next;
  logic          das_dir_reg, das_dir_next;
  logic          das_rep_reg, das_rep_next;
  logic          rot_pend_reg, rot_pend_next;
  logic          mv_pend_reg, mv_pend_next;
  logic          mv_dir_reg, mv_dir_next;
  logic          down_pend_reg, down_pend_next;
  logic          left_q_reg, right_q_reg, rot_q_reg;

  logic          left_rise, right_rise, rot_rise;
  logic          grav_fire, mv_fire, mv_fire_dir;
  logic [PW-1:0] grav_dec, grav_raw;

  assign left_rise  = left_i & ~left_q_reg;
  assign right_rise = right_i & ~right_q_reg;
  assign rot_rise   = rotate_i & ~rot_q_reg;

  assign cmd_valid_o   = cmd_valid_reg;
  assign cmd_o         = cmd_reg;
  assign grav_period_o = grav_period_reg;

  // Period is computed wide so a large level*step underflows visibly instead of wrapping.
  always_comb begin
    grav_dec = PW'(level_i) * STEP_W;
    grav_raw = BASE_W - grav_dec;
    if (drop_i || (grav_dec > BASE_W) || (grav_raw < MIN_W))
      period_next = MIN_W[CW-1:0];
    else
      period_next = grav_raw[CW-1:0];
  end

  always_comb begin
    state_next      = state_reg;
    cmd_valid_next  = cmd_valid_reg;
    cmd_next        = cmd_reg;
    grav_cnt_next   = grav_cnt_reg;
    das_cnt_next    = das_cnt_reg;
    das_active_next = das_active_reg;
    das_dir_next    = das_dir_reg;
    das_rep_next    = das_rep_reg;
    rot_pend_next   = rot_pend_reg;
    mv_pend_next    = mv_pend_reg;
    mv_dir_next     = mv_dir_reg;
    down_pend_next  = down_pend_reg;
    grav_fire       = 1'b0;
    mv_fire         = 1'b0;
    mv_fire_dir     = 1'b0;

    if (lock_i || !enable_i) begin
      state_next      = IDLE;
      cmd_valid_next  = 1'b0;
      cmd_next        = CMD_NONE;
      grav_cnt_next   = '0;
      das_cnt_next    = '0;
      das_active_next = 1'b0;
      das_rep_next    = 1'b0;
      rot_pend_next   = 1'b0;
      mv_pend_next    = 1'b0;
      down_pend_next  = 1'b0;
    end else begin
      // >= rather than == so a shortened period fires at once instead of running past it
      if (grav_cnt_reg >= grav_period_reg - CNT_ONE) begin
        grav_fire     = 1'b1;
        grav_cnt_next = '0;
      end else begin
        grav_cnt_next = grav_cnt_reg + CNT_ONE;
      end

      if (left_i && right_i) begin
        das_active_next = 1'b0;
        das_cnt_next    = '0;
        das_rep_next    = 1'b0;
      end else if (left_rise || right_rise) begin
        mv_fire         = 1'b1;
        mv_fire_dir     = right_rise;
        das_active_next = 1'b1;
        das_dir_next    = right_rise;
        das_cnt_next    = '0;
        das_rep_next    = 1'b0;
      end else if (das_active_reg && (das_dir_reg ? right_i : left_i)) begin
        if (das_rep_reg ? (das_cnt_reg == REP_LAST) : (das_cnt_reg == DLY_LAST)) begin
          mv_fire      = 1'b1;
          mv_fire_dir  = das_dir_reg;
          das_cnt_next = '0;
          das_rep_next = 1'b1;
        end else begin
          das_cnt_next = das_cnt_reg + CNT_ONE;
        end
      end else begin
        das_active_next = 1'b0;
        das_cnt_next    = '0;
        das_rep_next    = 1'b0;
      end

      rot_pend_next  = rot_pend_reg | rot_rise;
      down_pend_next = down_pend_reg | grav_fire;
      if (mv_fire) begin
        mv_pend_next = 1'b1;
        mv_dir_next  = mv_fire_dir;
      end

      // A flag is consumed when its command is captured, so an event during ISSUE re-arms it.
      case (state_reg)
        IDLE: begin
          if (rot_pend_next) begin
            cmd_next       = CMD_ROTATE;
            rot_pend_next  = 1'b0;
            cmd_valid_next = 1'b1;
            state_next     = ISSUE;
          end else if (mv_pend_next) begin
            cmd_next       = mv_dir_next ? CMD_RIGHT : CMD_LEFT;
            mv_pend_next   = 1'b0;
            cmd_valid_next = 1'b1;
            state_next     = ISSUE;
          end else if (down_pend_next) begin
            cmd_next       = CMD_DOWN;
            down_pend_next = 1'b0;
            cmd_valid_next = 1'b1;
            state_next     = ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_ready_i) begin
            cmd_valid_next = 1'b0;
            cmd_next       = CMD_NONE;
            state_next     = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      cmd_valid_reg   <= 1'b0;
      cmd_reg         <= CMD_NONE;
      grav_period_reg <= BASE_W[CW-1:0];
      grav_cnt_reg    <= '0;
      das_cnt_reg     <= '0;
      das_active_reg  <= 1'b0;
      das_dir_reg     <= 1'b0;
      das_rep_reg     <= 1'b0;
      rot_pend_reg    <= 1'b0;
      mv_pend_reg     <= 1'b0;
      mv_dir_reg      <= 1'b0;
      down_pend_reg   <= 1'b0;
      left_q_reg      <= 1'b0;
      right_q_reg     <= 1'b0;
      rot_q_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cmd_valid_reg   <= cmd_valid_next;
      cmd_reg         <= cmd_next;
      grav_period_reg <= period_next;
      grav_cnt_reg    <= grav_cnt_next;
      das_cnt_reg     <= das_cnt_next;
      das_active_reg  <= das_active_next;
      das_dir_reg     <= das_dir_next;
      das_rep_reg     <= das_rep_next;
      rot_pend_reg    <= rot_pend_next;
      mv_pend_reg     <= mv_pend_next;
      mv_dir_reg      <= mv_dir_next;
      down_pend_reg   <= down_pend_next;
      left_q_reg      <= left_i;
      right_q_reg     <= right_i;
      rot_q_reg       <= rotate_i;
    end
  end

endmodule

// File: tb/tb_tetris_move_sched.sv
// Bench for tetris_move_sched: per-cycle behavioural model check under random stimulus
// plus directed scenarios with hand-computed cycle-exact expectations.
module tb_tetris_move_sched;

  localparam int CW = 8, BASE = 20, STEP = 2, GMIN = 4, DLY = 6, REP = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable_i = 1'b0;
  logic [3:0]    level_i = '0;
  logic          left_i = 1'b0, right_i = 1'b0, rotate_i = 1'b0, drop_i = 1'b0, lock_i = 1'b0;
  logic          cmd_valid_o;
  logic [2:0]    cmd_o;
  logic          cmd_ready_i = 1'b1;
  logic [CW-1:0] grav_period_o;

  int n_tests = 0;
  int n_fail  = 0;

  tetris_move_sched #(
    .CW(CW), .GRAV_BASE(BASE), .GRAV_STEP(STEP), .GRAV_MIN(GMIN),
    .DAS_DELAY(DLY), .DAS_REPEAT(REP)
  ) dut (
    .clk(clk), .reset(reset), .enable_i(enable_i), .level_i(level_i),
    .left_i(left_i), .right_i(right_i), .rotate_i(rotate_i), .drop_i(drop_i),
    .lock_i(lock_i), .cmd_valid_o(cmd_valid_o), .cmd_o(cmd_o),
    .cmd_ready_i(cmd_ready_i), .grav_period_o(grav_period_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model state: pending set, gravity age, held button and hold time, command in flight.
  int m_period, m_gage, m_hold, m_held, m_mvdir, m_cmd;
  bit m_rot, m_mv, m_dn, m_valid, p_l, p_r, p_rot;

  function automatic int period_of(input int lvl, input bit drop);
    int p;
    p = BASE - lvl * STEP;
    if (drop || p < GMIN) return GMIN;
    return p;
  endfunction

  task automatic model_reset();
    m_period = BASE; m_gage = 0; m_hold = 0; m_held = 0; m_mvdir = 0; m_cmd = 0;
    m_rot = 0; m_mv = 0; m_dn = 0; m_valid = 0; p_l = 0; p_r = 0; p_rot = 0;
  endtask

  task automatic model_step();
    bit lr, rr, re, g_ev;
    int mv_ev;
    lr = left_i && !p_l;
    rr = right_i && !p_r;
    re = rotate_i && !p_rot;
    g_ev = 0;
    mv_ev = 0;
    if (lock_i || !enable_i) begin
      m_rot = 0; m_mv = 0; m_dn = 0; m_gage = 0; m_held = 0; m_valid = 0; m_cmd = 0;
    end else begin
      if (m_gage >= m_period - 1) begin g_ev = 1; m_gage = 0; end
      else m_gage++;
      // DAS: a move at the press, one DLY cycles later, then every REP cycles while held
      if (left_i && right_i) m_held = 0;
      else if (lr) begin m_held = 1; m_hold = 0; mv_ev = 1; end
      else if (rr) begin m_held = 2; m_hold = 0; mv_ev = 2; end
      else if ((m_held == 1 && left_i) || (m_held == 2 && right_i)) begin
        m_hold++;
        if (m_hold == DLY || (m_hold > DLY && (m_hold - DLY) % REP == 0)) mv_ev = m_held;
      end else m_held = 0;
      if (re) m_rot = 1;
      if (g_ev) m_dn = 1;
      if (mv_ev != 0) begin m_mv = 1; m_mvdir = mv_ev; end
      if (m_valid) begin
        if (cmd_ready_i) begin m_valid = 0; m_cmd = 0; end
      end else if (m_rot) begin m_rot = 0; m_valid = 1; m_cmd = 3; end
      else if (m_mv) begin m_mv = 0; m_valid = 1; m_cmd = m_mvdir; end
      else if (m_dn) begin m_dn = 0; m_valid = 1; m_cmd = 4; end
    end
    m_period = period_of(int'(level_i), drop_i);
    p_l = left_i; p_r = right_i; p_rot = rotate_i;
  endtask

  always @(negedge clk) begin
    if (reset) model_reset();
    else begin
      check("model_valid", int'(cmd_valid_o), int'(m_valid));
      check("model_cmd", int'(cmd_o), m_cmd);
      check("model_period", int'(grav_period_o), m_period);
      if (cmd_valid_o && cmd_ready_i)
        $display("[TB] t=%0t cmd %0d accepted", $time, cmd_o);
      model_step();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input bit v, input int c);
    check({nm, "_valid"}, int'(cmd_valid_o), int'(v));
    check({nm, "_cmd"}, int'(cmd_o), c);
  endtask

  task automatic do_lock();
    tick(); lock_i = 1;
    tick(); lock_i = 0;
  endtask

  initial begin
    model_reset();
    tick(); tick();
    chk_out("reset", 1'b0, 0);
    check("reset_period", int'(grav_period_o), 20);
    reset = 0; enable_i = 1; level_i = 0; cmd_ready_i = 1;

    // Level 0 gravity every 20 cycles, then rotate coinciding with a gravity tick.
    do_lock();
    for (int k = 1; k <= 43; k++) begin
      rotate_i = (k == 40);
      if (k == 21 || k == 43) chk_out("grav_down", 1'b1, 4);
      else if (k == 41) chk_out("rot_first", 1'b1, 3);
      else chk_out("grav_gap", 1'b0, 0);
      tick();
    end

    // Level 9 floors at GRAV_MIN.
    level_i = 9; lock_i = 1;
    tick(); lock_i = 0;
    check("lvl9_period", int'(grav_period_o), 4);
    for (int k = 1; k <= 9; k++) begin
      if (k == 5 || k == 9) chk_out("lvl9_down", 1'b1, 4);
      else chk_out("lvl9_gap", 1'b0, 0);
      tick();
    end
    level_i = 0;

    // Left held 15 cycles: moves at +1, +7, +10, +13.
    do_lock();
    for (int k = 0; k <= 18; k++) begin
      left_i = (k <= 14);
      if (k == 1 || k == 7 || k == 10 || k == 13) chk_out("das_left", 1'b1, 1);
      else chk_out("das_gap", 1'b0, 0);
      tick();
    end
    left_i = 0;

    // ROTATE stalled 8 cycles, second rotate edge during the stall gives one extra ROTATE.
    do_lock();
    for (int k = 0; k <= 18; k++) begin
      rotate_i = (k == 0 || k == 3);
      cmd_ready_i = (k >= 9);
      if ((k >= 1 && k <= 9) || k == 11) chk_out("stall_rot", 1'b1, 3);
      else chk_out("stall_gap", 1'b0, 0);
      tick();
    end
    rotate_i = 0; cmd_ready_i = 1;

    // lock during ISSUE(RIGHT) with right held; gravity restarts from the lock.
    do_lock();
    for (int k = 0; k <= 23; k++) begin
      right_i = (k <= 15) || (k == 17);
      cmd_ready_i = (k >= 3);
      lock_i = (k == 2);
      if (k == 1 || k == 2 || k == 18) chk_out("lock_right", 1'b1, 2);
      else if (k == 23) chk_out("lock_grav", 1'b1, 4);
      else chk_out("lock_gap", 1'b0, 0);
      tick();
    end
    right_i = 0; lock_i = 0; cmd_ready_i = 1;

    // Both directions held: no move, gravity still runs.
    do_lock();
    for (int k = 0; k <= 21; k++) begin
      left_i = (k <= 9);
      right_i = (k <= 9);
      if (k == 20) chk_out("both_down", 1'b1, 4);
      else chk_out("both_gap", 1'b0, 0);
      tick();
    end
    left_i = 0; right_i = 0;

    // Asynchronous reset in the middle of a stalled handshake.
    level_i = 5;
    do_lock();
    rotate_i = 1; cmd_ready_i = 0;
    tick(); rotate_i = 0;
    chk_out("pre_areset", 1'b1, 3);
    #2 reset = 1;
    #1 chk_out("areset", 1'b0, 0);
    check("areset_period", int'(grav_period_o), 20);
    tick(); reset = 0; cmd_ready_i = 1;

    // Randomised phase, checked by the model every cycle.
    for (int i = 0; i < 4000; i++) begin
      tick();
      if ($urandom_range(0, 9) == 0) left_i = ~left_i;
      if ($urandom_range(0, 12) == 0) right_i = ~right_i;
      if ($urandom_range(0, 4) == 0) rotate_i = ~rotate_i;
      if ($urandom_range(0, 30) == 0) drop_i = ~drop_i;
      if ($urandom_range(0, 60) == 0) level_i = 4'($urandom_range(0, 15));
      if (enable_i) enable_i = ($urandom_range(0, 99) != 0);
      else enable_i = ($urandom_range(0, 4) == 0);
      lock_i = ($urandom_range(0, 49) == 0);
      cmd_ready_i = ($urandom_range(0, 3) != 0);
    end
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
